// File: rtl/reg_wb_arbiter_pkg.sv
// Shared widths, constants and types for the register writeback arbiter.
package reg_wb_arbiter_pkg;

    // Datapath and register-address widths
    localparam int reg_bus      = 32;
    localparam int reg_addr_bus = 5;

    // Generic single-bit constants
    localparam logic zero_v = 1'b0;
    localparam logic true_v = 1'b1;

    // Round-robin last-grant encodings
    localparam logic RR_A = 1'b0;
    localparam logic RR_B = 1'b1;

    // Level of rst that holds the block in reset
    localparam logic rst_n_enable = 1'b0;

    typedef logic [reg_bus-1:0]      reg_data_t;
    typedef logic [reg_addr_bus-1:0] reg_addr_t;

    // One writeback request as presented by either port
    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } wb_req_t;

    // Register 0 is hardwired; only nonzero destinations are architectural
    function automatic logic addr_live(input reg_addr_t addr);
        return (addr != '0);
    endfunction

endpackage

// File: rtl/reg_wb_arbiter_rr_arb2.sv
// Two-way round-robin selector: a lone requester always wins, on a
// conflict the side that did not win last time is chosen.
module rr_arb2
    import reg_wb_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Pick the winner; bit 0 is port A, bit 1 is port B
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == RR_A) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter: grants one of two writeback ports per
// cycle, drives the registered register-file write port and keeps a
// pending-destination scoreboard that stalls decode on unresolved sources.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int   NUM_REGS = 32,
    parameter logic RR_INIT  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    input  logic [reg_addr_bus-1:0] issue_addr,
    input  logic [reg_addr_bus-1:0] rs_addr,
    input  logic [reg_addr_bus-1:0] rt_addr,
    output logic                    stall,
    input  logic                    flush,
    input  logic                    a_req,
    input  logic [reg_addr_bus-1:0] a_addr,
    input  logic [reg_bus-1:0]      a_data,
    output logic                    a_gnt,
    input  logic                    b_req,
    input  logic [reg_addr_bus-1:0] b_addr,
    input  logic [reg_bus-1:0]      b_data,
    output logic                    b_gnt,
    output logic                    we,
    output logic [reg_addr_bus-1:0] write_addr,
    output logic [reg_bus-1:0]      write_data,
    output logic [NUM_REGS-1:0]     pending
);

    logic                last_grant;
    logic [1:0]          arb_req;
    logic [1:0]          arb_gnt;
    logic                gnt_any;
    wb_req_t             winner;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic [NUM_REGS-1:0] pending_next;

    // Decode a destination into a one-hot scoreboard mask; register 0 never maps
    function automatic logic [NUM_REGS-1:0] addr_mask(input reg_addr_t addr);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (addr_live(addr)) begin
            m[addr] = 1'b1;
        end
        return m;
    endfunction

    // Requests are masked in reset and during a flush so no grant can escape
    always_comb begin
        arb_req = 2'b00;
        if ((rst != rst_n_enable) && !flush) begin
            arb_req = {b_req, a_req};
        end
    end

    rr_arb2 u_rr_arb2 (
        .req  (arb_req),
        .last (last_grant),
        .gnt  (arb_gnt)
    );

    assign a_gnt   = arb_gnt[0];
    assign b_gnt   = arb_gnt[1];
    assign gnt_any = arb_gnt[0] | arb_gnt[1];

    // Route the winning port's destination and value toward the write port
    always_comb begin
        winner = '{addr: a_addr, data: a_data};
        if (arb_gnt[1]) begin
            winner = '{addr: b_addr, data: b_data};
        end
    end

    // Remember which side won last; only a real grant moves the pointer
    always_ff @(posedge clk or negedge rst) begin
        if (rst == rst_n_enable) begin
            last_grant <= RR_INIT;
        end else if (gnt_any) begin
            last_grant <= arb_gnt[1] ? RR_B : RR_A;
        end
    end

    // Register-file write port: one-cycle latency, register 0 writes are dropped
    always_ff @(posedge clk or negedge rst) begin
        if (rst == rst_n_enable) begin
            we         <= zero_v;
            write_addr <= '0;
            write_data <= '0;
        end else begin
            we <= (gnt_any && addr_live(winner.addr)) ? true_v : zero_v;
            if (gnt_any) begin
                write_addr <= winner.addr;
                write_data <= winner.data;
            end
        end
    end

    // Scoreboard update: issue sets, writeback clears, set wins a same-cycle tie
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_valid) begin
            set_vec = addr_mask(issue_addr);
        end
        if (gnt_any) begin
            clr_vec = addr_mask(winner.addr);
        end
        if (flush) begin
            pending_next = '0;
        end else begin
            pending_next = (pending & ~clr_vec) | set_vec;
        end
        pending_next[0] = zero_v;
    end

    // Scoreboard register; everything outstanding is forgotten on reset
    always_ff @(posedge clk or negedge rst) begin
        if (rst == rst_n_enable) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // Decode hold: either nonzero source still waiting on its writeback
    always_comb begin
        stall = (addr_live(rs_addr) && pending[rs_addr]) ||
                (addr_live(rt_addr) && pending[rt_addr]);
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench for reg_wb_arbiter: stimulus queues expected grants and
// write-port results, a negedge monitor pops and compares them.
module tb_reg_wb_arbiter;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_addr, rs_addr, rt_addr;
    logic        stall, flush;
    logic        a_req, b_req, a_gnt, b_gnt;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        we;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [31:0] pending;

    int passed = 0;
    int total  = 0;

    int      exp_gnt_q[$];
    exp_wr_t exp_wr_q[$];
    logic    wr_due = 1'b0;

    reg_wb_arbiter #(.NUM_REGS(32), .RR_INIT(1'b1)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .stall(stall), .flush(flush),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_gnt(a_gnt),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_gnt(b_gnt),
        .we(we), .write_addr(write_addr), .write_data(write_data),
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic exp_grant(input int port, input logic w, input logic [4:0] ad, input logic [31:0] d);
        exp_wr_t e;
        e.we = w; e.addr = ad; e.data = d;
        exp_gnt_q.push_back(port);
        exp_wr_q.push_back(e);
    endtask

    // Monitor: grants checked in their own cycle, write port one cycle later
    always @(negedge clk) begin
        exp_wr_t e;
        if (wr_due) begin
            if (exp_wr_q.size() == 0) begin
                chk("wr_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_wr_q.pop_front();
                chk("wr_we", {31'd0, we}, {31'd0, e.we});
                chk("wr_addr", {27'd0, write_addr}, {27'd0, e.addr});
                chk("wr_data", write_data, e.data);
            end
        end
        wr_due = a_gnt | b_gnt;
        if (a_gnt && b_gnt) chk("both_gnt", 32'd1, 32'd0);
        if (a_gnt || b_gnt) begin
            if (exp_gnt_q.size() == 0) chk("gnt_unexpected", {31'd0, b_gnt}, 32'hFFFF_FFFF);
            else chk("gnt_port", {31'd0, b_gnt}, exp_gnt_q.pop_front());
        end
    end

    // Reset discards any write still in flight
    always @(negedge rst) begin
        wr_due = 1'b0;
        exp_wr_q.delete();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_addr = '0;
        rs_addr = '0; rt_addr = '0;
        a_req = 1'b1; a_addr = 5'd3; a_data = 32'h1;
        b_req = 1'b1; b_addr = 5'd4; b_data = 32'h2;

        // Reset state with both ports requesting
        tick(); tick();
        chk("rst_a_gnt", {31'd0, a_gnt}, 32'd0);
        chk("rst_b_gnt", {31'd0, b_gnt}, 32'd0);
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_waddr", {27'd0, write_addr}, 32'd0);
        chk("rst_wdata", write_data, 32'd0);
        chk("rst_pending", pending, 32'd0);
        a_req = 1'b0; b_req = 1'b0;
        rst = 1'b1;

        // Single A request, one-cycle write latency
        tick();
        a_req = 1'b1; a_addr = 5'd5; a_data = 32'h0000_1234;
        exp_grant(0, 1'b1, 5'd5, 32'h0000_1234);
        settle();
        chk("a_gnt_same_cycle", {31'd0, a_gnt}, 32'd1);
        tick();
        a_req = 1'b0;
        tick(); tick();

        // Reset so arbitration restarts favouring A
        rst = 1'b0; #2; rst = 1'b1;
        tick();

        // Held conflict alternates A,B,A,B
        a_req = 1'b1; a_addr = 5'd3; a_data = 32'hAAAA_0003;
        b_req = 1'b1; b_addr = 5'd4; b_data = 32'hBBBB_0004;
        exp_grant(0, 1'b1, 5'd3, 32'hAAAA_0003);
        exp_grant(1, 1'b1, 5'd4, 32'hBBBB_0004);
        exp_grant(0, 1'b1, 5'd3, 32'hAAAA_0003);
        exp_grant(1, 1'b1, 5'd4, 32'hBBBB_0004);
        tick(); tick(); tick(); tick();
        a_req = 1'b0; b_req = 1'b0;
        tick();

        // Issue 7, stall on rs=7 until B writes it back
        issue_valid = 1'b1; issue_addr = 5'd7;
        tick();
        issue_valid = 1'b0; rs_addr = 5'd7;
        settle();
        chk("pend7_set", pending, 32'h0000_0080);
        chk("stall7", {31'd0, stall}, 32'd1);
        b_req = 1'b1; b_addr = 5'd7; b_data = 32'h0000_0077;
        exp_grant(1, 1'b1, 5'd7, 32'h0000_0077);
        settle();
        chk("stall7_in_gnt", {31'd0, stall}, 32'd1);
        tick();
        b_req = 1'b0;
        settle();
        chk("pend7_clr", pending, 32'd0);
        chk("stall7_clr", {31'd0, stall}, 32'd0);

        // Register 0: grant writes nothing, issue sets nothing, no stall
        a_req = 1'b1; a_addr = 5'd0; a_data = 32'h0000_DEAD;
        issue_valid = 1'b1; issue_addr = 5'd0;
        exp_grant(0, 1'b0, 5'd0, 32'h0000_DEAD);
        tick();
        a_req = 1'b0; issue_valid = 1'b0; rs_addr = 5'd0; rt_addr = 5'd0;
        settle();
        chk("pend_r0", pending, 32'd0);
        chk("stall_r0", {31'd0, stall}, 32'd0);
        tick();
        chk("idle_we", {31'd0, we}, 32'd0);
        chk("idle_wdata_hold", write_data, 32'h0000_DEAD);

        // Issue and grant to 9 in one cycle: set wins
        issue_valid = 1'b1; issue_addr = 5'd9;
        a_req = 1'b1; a_addr = 5'd9; a_data = 32'h0000_0099;
        exp_grant(0, 1'b1, 5'd9, 32'h0000_0099);
        tick();
        issue_valid = 1'b0; a_req = 1'b0; rs_addr = 5'd9;
        settle();
        chk("pend9_keep", pending, 32'h0000_0200);
        chk("stall9", {31'd0, stall}, 32'd1);
        b_req = 1'b1; b_addr = 5'd9; b_data = 32'h0000_9999;
        exp_grant(1, 1'b1, 5'd9, 32'h0000_9999);
        tick();
        b_req = 1'b0; rs_addr = 5'd0;
        settle();
        chk("pend9_clr", pending, 32'd0);

        // Flush with 0xF00 pending, requests and an issue all suppressed
        for (int r = 8; r < 12; r++) begin
            issue_valid = 1'b1; issue_addr = 5'(r);
            tick();
        end
        issue_valid = 1'b0; rt_addr = 5'd10;
        settle();
        chk("pend_f00", pending, 32'h0000_0F00);
        chk("stall_rt10", {31'd0, stall}, 32'd1);
        flush = 1'b1; issue_valid = 1'b1; issue_addr = 5'd12;
        a_req = 1'b1; a_addr = 5'd1; a_data = 32'hA1;
        b_req = 1'b1; b_addr = 5'd2; b_data = 32'hB2;
        settle();
        chk("flush_a_gnt", {31'd0, a_gnt}, 32'd0);
        chk("flush_b_gnt", {31'd0, b_gnt}, 32'd0);
        tick();
        flush = 1'b0; issue_valid = 1'b0;
        exp_grant(0, 1'b1, 5'd1, 32'hA1);
        settle();
        chk("flush_pending", pending, 32'd0);
        chk("flush_we", {31'd0, we}, 32'd0);
        chk("flush_stall", {31'd0, stall}, 32'd0);
        tick();
        a_req = 1'b0;
        exp_grant(1, 1'b1, 5'd2, 32'hB2);
        tick();
        b_req = 1'b0;
        tick();

        // Asynchronous reset mid-cycle with a write in flight
        for (int r = 8; r < 12; r++) begin
            issue_valid = 1'b1; issue_addr = 5'(r);
            tick();
        end
        issue_valid = 1'b0;
        b_req = 1'b1; b_addr = 5'd8; b_data = 32'h0000_0088;
        exp_grant(1, 1'b1, 5'd8, 32'h0000_0088);
        tick();
        settle();
        chk("pre_rst_we", {31'd0, we}, 32'd1);
        chk("pre_rst_pending", pending, 32'h0000_0E00);
        rst = 1'b0;
        settle();
        chk("arst_pending", pending, 32'd0);
        chk("arst_we", {31'd0, we}, 32'd0);
        chk("arst_stall", {31'd0, stall}, 32'd0);
        chk("arst_b_gnt", {31'd0, b_gnt}, 32'd0);
        b_req = 1'b0;
        settle();
        rst = 1'b1;
        tick();
        a_req = 1'b1; a_addr = 5'd1; a_data = 32'h0000_0A01;
        b_req = 1'b1; b_addr = 5'd2; b_data = 32'h0000_0B02;
        exp_grant(0, 1'b1, 5'd1, 32'h0000_0A01);
        settle();
        chk("post_rst_a_first", {31'd0, a_gnt}, 32'd1);
        tick();
        a_req = 1'b0;
        exp_grant(1, 1'b1, 5'd2, 32'h0000_0B02);
        tick();
        b_req = 1'b0;
        tick(); tick();

        chk("gnt_q_empty", exp_gnt_q.size(), 32'd0);
        chk("wr_q_empty", exp_wr_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 Parameter: NUM_REGS, default 32, number of architectural registers tracked; the value is fixed at 32.
REQ-002 Parameter: RR_INIT, default 1, last-grant value loaded at reset, so port A wins the first conflict.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 issue_valid  input  1  an instruction with a register destination issues this cycle.
REQ-006 issue_addr  input  5  destination register of the issuing instruction.
REQ-007 rs_addr  input  5  first source register of the instruction in decode.
REQ-008 rt_addr  input  5  second source register of the instruction in decode.
REQ-009 stall  output  1  decode must hold; a source operand is still pending.
REQ-010 flush  input  1  pipeline flush; cancels all outstanding destinations.
REQ-011 a_req, a_addr, a_data  input  1/5/32  execute-stage writeback request, destination and value.
REQ-012 a_gnt  output  1  port A request accepted this cycle.
REQ-013 b_req, b_addr, b_data  input  1/5/32  load writeback request, destination and value.
REQ-014 b_gnt  output  1  port B request accepted this cycle.
REQ-015 we, write_addr, write_data  output  1/5/32  registered drive of the register-file write port.
REQ-016 pending  output  32  scoreboard; bit i set means register i awaits writeback.

Function
REQ-017 Requesters SHALL hold req, addr and data stable until granted; a_gnt and b_gnt are combinational in the same cycle.
REQ-018 Single request: that port SHALL be granted.
REQ-019 Both ports requesting: the port not granted last SHALL win; last_grant updates only on an actual grant.
REQ-020 At most one grant SHALL be asserted per cycle.
REQ-021 On a grant, the next edge SHALL load write_addr and write_data from the winner; write latency is 1 cycle.
REQ-022 On a grant, the same edge SHALL set we=1 only if the granted address is nonzero.
REQ-023 With no grant, we SHALL be 0 at the next edge; write_addr and write_data hold their values.
REQ-024 A grant to register 0 SHALL be consumed with we=0 and no scoreboard change.
REQ-025 On issue_valid with issue_addr != 0, the edge SHALL set pending[issue_addr].
REQ-026 On a grant, the edge SHALL clear pending[granted addr]. The register-file same-cycle bypass covers the following cycle.
REQ-027 Issue and grant to the same address in one cycle: set SHALL win and the bit remains 1.
REQ-028 stall SHALL equal (rs_addr != 0 and pending[rs_addr]) or (rt_addr != 0 and pending[rt_addr]).
REQ-029 stall SHALL be combinational on the current pending vector.
REQ-030 pending[0] SHALL always read 0.
REQ-031 flush=1 SHALL, at the edge, clear all pending bits and ignore issue_valid.
REQ-032 flush SHALL suppress both grants that cycle, and we=0 follows at the next edge.

Reset
REQ-033 rst=0 SHALL asynchronously force we=0, write_addr=0, write_data=0, pending=0 and last_grant=RR_INIT.
REQ-034 Grants SHALL be 0 while rst=0.
REQ-035 A reset during any operation SHALL discard every in-flight write and scoreboard entry; arbitration restarts with A favoured.
REQ-036 After rst rises, the first rising edge SHALL be a normal operating edge.

Structure
REQ-037 Widths (reg_bus, reg_addr_bus) and constants (zero_v, true_v) SHALL come from the shared defines file.
REQ-038 New constants RR_A=0, RR_B=1 and rst_n_enable=0 SHALL be added to the shared defines file.
REQ-039 Two-way round-robin selection SHALL be one sub-module, rr_arb2 (req[1:0], last, gnt[1:0]).
REQ-040 The scoreboard and the write-port register SHALL stay in reg_wb_arbiter.

Verification
REQ-041 Reset, then a_req with addr 5, data 0x1234 -> a_gnt=1 same cycle; next cycle we=1, write_addr=5, write_data=0x1234.
REQ-042 a_req and b_req held 4 cycles, addr 3 and 4 -> grant order A,B,A,B; no cycle with both grants.
REQ-043 issue_valid, issue_addr=7; next cycle rs_addr=7 -> stall=1; b grant on 7 -> stall=0 the following cycle, pending[7]=0.
REQ-044 issue_addr=9 with a grant on addr 9 in the same cycle -> pending[9]=1 afterwards, stall stays 1 for rs_addr=9.
REQ-045 a grant to addr 0 -> we=0; issue_addr=0 -> pending=0; rs_addr=0 -> stall=0.
REQ-046 pending=0x0000_0F00, then flush or asynchronous rst=0 mid-cycle -> pending=0, we=0, stall=0, and the next conflict is granted to A.
